// File: rtl/pc_branch_unit.sv
// Program counter and control-transfer unit for the single-cycle RV32I core.
// Resolves JAL/JALR/branches, produces link writes, traps misaligned targets and tracks a return-address stack.
module pc_branch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              RAS_DEPTH    = 4,
  parameter int              CNT_W        = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic            stall,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic            link_wr_en,
  output logic [4:0]      link_rd,
  output logic [XLEN-1:0] link_data,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr,
  output logic [CNT_W-1:0] ras_hit_cnt,
  output logic [CNT_W-1:0] ras_miss_cnt
);

  localparam int PTR_W  = $clog2(RAS_DEPTH);
  localparam int RCNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [XLEN-1:0]   FOUR     = XLEN'(4);
  localparam logic [XLEN-1:0]   LSB_MASK = ~XLEN'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [RCNT_W-1:0] RCNT_ONE = RCNT_W'(1);
  localparam logic [RCNT_W-1:0] RAS_FULL = RCNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [4:0]      rs1_idx;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign rd      = instr[11:7];
  assign rs1_idx = instr[19:15];

  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  logic is_jal;
  logic is_jalr;
  logic is_branch;

  // BRANCH with funct3 010/011 is not a real encoding and falls through as sequential.
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR) && (funct3 == 3'b000);
  assign is_branch = (opcode == OP_BRANCH) && (funct3 != 3'b010) && (funct3 != 3'b011);

  logic br_eq;
  logic br_lt;
  logic br_ltu;
  logic branch_cond;

  assign br_eq  = (rs1_data == rs2_data);
  assign br_lt  = ($signed(rs1_data) < $signed(rs2_data));
  assign br_ltu = (rs1_data < rs2_data);

  always_comb begin
    branch_cond = 1'b0;
    case (funct3)
      3'b000:  branch_cond = br_eq;
      3'b001:  branch_cond = !br_eq;
      3'b100:  branch_cond = br_lt;
      3'b101:  branch_cond = !br_lt;
      3'b110:  branch_cond = br_ltu;
      3'b111:  branch_cond = !br_ltu;
      default: branch_cond = 1'b0;
    endcase
  end

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] target;
  logic            taken;
  logic            misaligned;
  logic            adv;

  assign pc_plus4    = pc + FOUR;
  assign jalr_target = (rs1_data + imm_i) & LSB_MASK;

  // target defaults to the fall-through address so not-taken cases share the same mux leg.
  always_comb begin
    taken  = 1'b0;
    target = pc_plus4;
    if (is_jal) begin
      taken  = 1'b1;
      target = pc + imm_j;
    end else if (is_jalr) begin
      taken  = 1'b1;
      target = jalr_target;
    end else if (is_branch && branch_cond) begin
      taken  = 1'b1;
      target = pc + imm_b;
    end
  end

  assign misaligned = taken && (target[1:0] != 2'b00);
  assign adv        = instr_valid && !stall && !reset;

  always_comb begin
    if (reset) begin
      next_pc = RESET_VECTOR;
    end else if (!adv) begin
      next_pc = pc;
    end else if (misaligned) begin
      next_pc = TRAP_VECTOR;
    end else begin
      next_pc = target;
    end
  end

  assign fault      = adv && misaligned;
  assign fault_addr = target;
  assign link_rd    = rd;
  assign link_data  = pc_plus4;
  assign link_wr_en = adv && (is_jal || is_jalr) && !misaligned && (rd != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_VECTOR;
    end else begin
      pc <= next_pc;
    end
  end

  logic            rd_link;
  logic            rs1_link;
  logic            ras_ok;
  logic            do_push;
  logic            do_pop;

  assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link = (rs1_idx == 5'd1) || (rs1_idx == 5'd5);
  assign ras_ok   = adv && !misaligned;

  // Every linking JAL/JALR pushes; a JALR pops when rs1 is a link register unless rd names the same one.
  assign do_push = ras_ok && (is_jal || is_jalr) && rd_link;
  assign do_pop  = ras_ok && is_jalr && rs1_link && (!rd_link || (rd != rs1_idx));

  logic [XLEN-1:0]   ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr;
  logic [RCNT_W-1:0] ras_count;
  logic [XLEN-1:0]   ras_top;
  logic              ras_empty;
  logic              pop_hit;

  assign ras_top   = ras_mem[ras_ptr - PTR_ONE];
  assign ras_empty = (ras_count == '0);
  assign pop_hit   = (ras_top == jalr_target);

  logic [PTR_W-1:0]  ptr_after_pop;
  logic [RCNT_W-1:0] count_after_pop;
  logic [PTR_W-1:0]  ptr_nxt;
  logic [RCNT_W-1:0] count_nxt;
  logic              ras_wr;
  logic [PTR_W-1:0]  ras_wr_idx;
  logic              hit_inc;
  logic              miss_inc;

  // A pop-then-push rewrites the slot just vacated, so the top is replaced and the depth is unchanged.
  always_comb begin
    ptr_after_pop   = ras_ptr;
    count_after_pop = ras_count;
    if (do_pop && !ras_empty) begin
      ptr_after_pop   = ras_ptr - PTR_ONE;
      count_after_pop = ras_count - RCNT_ONE;
    end
    ptr_nxt    = ptr_after_pop;
    count_nxt  = count_after_pop;
    ras_wr     = 1'b0;
    ras_wr_idx = ptr_after_pop;
    if (do_push) begin
      ras_wr    = 1'b1;
      ptr_nxt   = ptr_after_pop + PTR_ONE;
      count_nxt = (count_after_pop == RAS_FULL) ? RAS_FULL : count_after_pop + RCNT_ONE;
    end
  end

  assign hit_inc  = do_pop && !ras_empty && pop_hit;
  assign miss_inc = do_pop && (ras_empty || !pop_hit);

  always_ff @(posedge clk) begin
    if (ras_wr) begin
      ras_mem[ras_wr_idx] <= pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ptr      <= '0;
      ras_count    <= '0;
      ras_hit_cnt  <= '0;
      ras_miss_cnt <= '0;
    end else begin
      ras_ptr   <= ptr_nxt;
      ras_count <= count_nxt;
      if (hit_inc && (ras_hit_cnt != CNT_MAX)) begin
        ras_hit_cnt <= ras_hit_cnt + CNT_ONE;
      end
      if (miss_inc && (ras_miss_cnt != CNT_MAX)) begin
        ras_miss_cnt <= ras_miss_cnt + CNT_ONE;
      end
    end
  end

endmodule
